// File: rtl/dmem_access_unit.sv
// Data-memory access unit for an RV32I MEM stage.
// Takes one load/store control word, checks it, and runs a single memory access
// through a three-state FSM (IDLE -> ACCESS -> RESP). The pipeline is frozen
// with stall until the access completes, then released with a one-cycle done.
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   req_valid       MEM-stage control word valid
//   mem_read        load request
//   mem_write       store request
//   funct3          width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   addr            byte address from the ALU
//   store_data      rs2 value, data in the low byte/half/word
//   dmem_read       registered memory read strobe
//   dmem_write      registered memory write strobe
//   dmem_address    word-aligned memory address
//   dmem_wdata      lane-replicated store data
//   dmem_mbe        byte enables
//   dmem_rdata      read data, valid with dmem_resp
//   dmem_resp       one-cycle completion from memory
//   load_data       registered, extended load result
//   done            one-cycle completion pulse to the pipeline
//   stall           pipeline freeze request
//   access_err      illegal or misaligned request; no access is issued
module dmem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic [31:0] load_data,
  output logic        done,
  output logic        stall,
  output logic        access_err
);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  state_e state_q, state_d;

  logic        rd_q;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  mbe_q;
  logic [31:0] load_q;
  logic [1:0]  lane_q;
  logic [2:0]  funct3_q;

  // Request decode
  logic        req;
  logic        rw_both;
  logic        legal_f3;
  logic        misaligned;
  logic        go;

  // Store formatting
  logic [3:0]  fmt_mbe;
  logic [31:0] fmt_wdata;

  // Load extraction
  logic [31:0] rdata_shift;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_ext;

  assign req     = req_valid & (mem_read ^ mem_write);
  assign rw_both = req_valid & mem_read & mem_write;

  always_comb begin
    legal_f3 = 1'b0;
    if (mem_read) begin
      unique case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_f3 = 1'b1;
        default:                                legal_f3 = 1'b0;
      endcase
    end else begin
      unique case (funct3)
        3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
        default:                legal_f3 = 1'b0;
      endcase
    end
  end

  // funct3[1:0] encodes the access size for every legal code.
  always_comb begin
    misaligned = 1'b0;
    unique case (funct3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign go         = (state_q == StIdle) & req & legal_f3 & ~misaligned;
  assign access_err = (state_q == StIdle) & (rw_both | (req & (~legal_f3 | misaligned)));

  always_comb begin
    fmt_mbe   = 4'b1111;
    fmt_wdata = store_data;
    if (mem_write) begin
      unique case (funct3[1:0])
        2'b00: begin
          fmt_mbe   = 4'b0001 << addr[1:0];
          fmt_wdata = {4{store_data[7:0]}};
        end
        2'b01: begin
          fmt_mbe   = 4'b0011 << addr[1:0];
          fmt_wdata = {2{store_data[15:0]}};
        end
        default: begin
          fmt_mbe   = 4'b1111;
          fmt_wdata = store_data;
        end
      endcase
    end
  end

  // Extraction uses the latched lane and width, never the live inputs.
  assign rdata_shift = dmem_rdata >> {lane_q, 3'b000};
  assign rbyte       = rdata_shift[7:0];
  assign rhalf       = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    load_ext = dmem_rdata;
    unique case (funct3_q)
      3'b000:  load_ext = {{24{rbyte[7]}}, rbyte};
      3'b001:  load_ext = {{16{rhalf[15]}}, rhalf};
      3'b100:  load_ext = {24'h000000, rbyte};
      3'b101:  load_ext = {16'h0000, rhalf};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (go) state_d = StAccess;
      StAccess: if (dmem_resp) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      mbe_q    <= 4'h0;
      load_q   <= 32'h0;
      lane_q   <= 2'b00;
      funct3_q <= 3'b000;
    end else begin
      state_q <= state_d;
      if (go) begin
        rd_q     <= mem_read;
        wr_q     <= mem_write;
        addr_q   <= {addr[31:2], 2'b00};
        wdata_q  <= fmt_wdata;
        mbe_q    <= fmt_mbe;
        lane_q   <= addr[1:0];
        funct3_q <= funct3;
      end
      if ((state_q == StAccess) && dmem_resp) begin
        rd_q <= 1'b0;
        wr_q <= 1'b0;
        // rd_q is still high on the response cycle of a load.
        if (rd_q) load_q <= load_ext;
      end
    end
  end

  assign dmem_read    = rd_q;
  assign dmem_write   = wr_q;
  assign dmem_address = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_mbe     = mbe_q;
  assign load_data    = load_q;
  assign done         = (state_q == StResp);
  assign stall        = go | (state_q == StAccess);

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: a table of complete load/store
// transactions plus hand-written sequences for reset, stray responses and
// back-to-back requests.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] load_data;
  logic        done;
  logic        stall;
  logic        access_err;

  int n_total = 0;
  int n_bad   = 0;

  dmem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .addr         (addr),
    .store_data   (store_data),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_address (dmem_address),
    .dmem_wdata   (dmem_wdata),
    .dmem_mbe     (dmem_mbe),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .load_data    (load_data),
    .done         (done),
    .stall        (stall),
    .access_err   (access_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          waits;
    logic        err;
    logic [31:0] e_addr;
    logic [3:0]  e_mbe;
    logic [31:0] e_wdata;
    logic [31:0] e_load;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v, input logic [31:0] exp_load);
    int rd_cycles;
    int wr_cycles;
    string tag;
    tag = $sformatf("v%0d", idx);
    rd_cycles = 0;
    wr_cycles = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    mem_read   = v.rd;
    mem_write  = v.wr;
    funct3     = v.f3;
    addr       = v.a;
    store_data = v.sd;
    #1;
    check({tag, " access_err"}, 32'(access_err), 32'(v.err));
    check({tag, " idle stall"}, 32'(stall), 32'(!v.err));
    if (v.err) begin
      @(posedge clk); #1;
      check({tag, " err no strobe"}, {30'h0, dmem_read, dmem_write}, 32'h0);
      check({tag, " err no done"}, 32'(done), 32'h0);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    // Scramble live inputs; the outstanding access must not notice.
    addr       = ~v.a;
    store_data = ~v.sd;
    funct3     = 3'b111;
    mem_read   = v.wr;
    mem_write  = v.rd;
    for (int i = 0; i <= v.waits; i++) begin
      if (dmem_read)  rd_cycles++;
      if (dmem_write) wr_cycles++;
      check({tag, " access stall"}, 32'(stall), 32'h1);
      check({tag, " address"}, dmem_address, v.e_addr);
      check({tag, " mbe"}, 32'(dmem_mbe), 32'(v.e_mbe));
      if (v.wr) check({tag, " wdata"}, dmem_wdata, v.e_wdata);
      check({tag, " access no done"}, 32'(done), 32'h0);
      if (i == v.waits) begin
        dmem_resp  = 1'b1;
        dmem_rdata = v.rdata;
      end
      @(posedge clk); #1;
      dmem_resp  = 1'b0;
      dmem_rdata = 32'h0;
    end
    req_valid = 1'b0;
    check({tag, " read cycles"}, 32'(rd_cycles), v.rd ? 32'(v.waits + 1) : 32'h0);
    check({tag, " write cycles"}, 32'(wr_cycles), v.wr ? 32'(v.waits + 1) : 32'h0);
    check({tag, " resp done"}, 32'(done), 32'h1);
    check({tag, " resp stall"}, 32'(stall), 32'h0);
    check({tag, " resp strobes"}, {30'h0, dmem_read, dmem_write}, 32'h0);
    check({tag, " load_data"}, load_data, exp_load);
    @(posedge clk); #1;
    check({tag, " done one cycle"}, 32'(done), 32'h0);
  endtask

  initial begin
    logic [31:0] last_load;
    int dones;
    int reads;
    logic prev_rd;

    rst        = 1'b1;
    req_valid  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = 3'b000;
    addr       = 32'h0;
    store_data = 32'h0;
    dmem_rdata = 32'h0;
    dmem_resp  = 1'b0;

    //           rd    wr    f3      addr          store_data    rdata        w  err   e_addr        mbe      wdata         load
    vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 3, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0,        32'h80FF7F01, 0, 1'b0, 32'h0000_0200, 4'b1111, 32'h0,        32'hFFFFFF80});
    vecs.push_back('{1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0,        32'h80FF7F01, 1, 1'b0, 32'h0000_0200, 4'b1111, 32'h0,        32'h00000080});
    vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0,        32'h80FF7F01, 0, 1'b0, 32'h0000_0200, 4'b1111, 32'h0,        32'hFFFF80FF});
    vecs.push_back('{1'b1, 1'b0, 3'b101, 32'h0000_0200, 32'h0,        32'h1234F00D, 2, 1'b0, 32'h0000_0200, 4'b1111, 32'h0,        32'h0000F00D});
    vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h0000_0201, 32'h0,        32'h1234F00D, 0, 1'b0, 32'h0000_0200, 4'b1111, 32'h0,        32'hFFFFFFF0});
    vecs.push_back('{1'b0, 1'b1, 3'b001, 32'h0000_0302, 32'h0000ABCD, 32'h0,        1, 1'b0, 32'h0000_0300, 4'b1100, 32'hABCDABCD, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h0000_0105, 32'h123456A5, 32'h0,        0, 1'b0, 32'h0000_0104, 4'b0010, 32'hA5A5A5A5, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h0000_0307, 32'h0000003C, 32'h0,        2, 1'b0, 32'h0000_0304, 4'b1000, 32'h3C3C3C3C, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'hCAFEF00D, 32'h0,        0, 1'b0, 32'h0000_0040, 4'b1111, 32'hCAFEF00D, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0});
    vecs.push_back('{1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0,        32'h0,        0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0});
    vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0,        32'h0,        0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0});
    vecs.push_back('{1'b1, 1'b0, 3'b101, 32'h0000_0103, 32'h0,        32'h0,        0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0});
    vecs.push_back('{1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0});
    vecs.push_back('{1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0,        32'h0,        0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0});

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset dmem_read", 32'(dmem_read), 32'h0);
    check("reset dmem_write", 32'(dmem_write), 32'h0);
    check("reset address", dmem_address, 32'h0);
    check("reset wdata", dmem_wdata, 32'h0);
    check("reset mbe", 32'(dmem_mbe), 32'h0);
    check("reset load_data", load_data, 32'h0);
    check("reset done/stall/err", {29'h0, done, stall, access_err}, 32'h0);

    // Stray response in IDLE must be ignored.
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h55555555;
    @(posedge clk); #1;
    dmem_resp  = 1'b0;
    check("idle resp no done", 32'(done), 32'h0);
    check("idle resp load_data", load_data, 32'h0);

    last_load = 32'h0;
    foreach (vecs[i]) begin
      logic [31:0] exp_load;
      exp_load = (vecs[i].rd && !vecs[i].wr) ? vecs[i].e_load : last_load;
      run_vec(i, vecs[i], exp_load);
      if (!vecs[i].err && vecs[i].rd) last_load = vecs[i].e_load;
    end
    check("load_data after errors", load_data, last_load);

    // Reset during ACCESS, then a late response.
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_0080;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst-seq read issued", 32'(dmem_read), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst        = 1'b0;
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h77777777;
    check("rst-seq strobes dropped", {30'h0, dmem_read, dmem_write}, 32'h0);
    check("rst-seq stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    check("rst-seq no done", 32'(done), 32'h0);
    check("rst-seq load_data", load_data, 32'h0);
    check("rst-seq idle strobes", {30'h0, dmem_read, dmem_write}, 32'h0);

    // Back-to-back: request held continuously, memory answers at once.
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_0400;
    dones   = 0;
    reads   = 0;
    prev_rd = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      if (dmem_read && !prev_rd) reads++;
      prev_rd = dmem_read;
      if (done) begin
        dones++;
        check("b2b resp no strobe", 32'(dmem_read), 32'h0);
        check("b2b resp stall", 32'(stall), 32'h0);
      end
      dmem_resp  = dmem_read;
      dmem_rdata = 32'h0000_0400 + 32'(c);
    end
    req_valid = 1'b0;
    dmem_resp = 1'b0;
    check("b2b accesses", 32'(reads), 32'd3);
    check("b2b dones", 32'(dones), 32'd3);
    @(posedge clk); #1;
    check("b2b quiet", {30'h0, dmem_read, done}, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed for RV32I.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 req_valid  input  1  MEM-stage control word valid.
REQ-005 mem_read  input  1  control-word load request.
REQ-006 mem_write  input  1  control-word store request.
REQ-007 funct3  input  3  control-word width/sign code.
REQ-008 addr  input  32  byte address from ALU.
REQ-009 store_data  input  32  rs2 value, data in bits [7:0]/[15:0]/[31:0].
REQ-010 dmem_read  output  1  memory read strobe, registered.
REQ-011 dmem_write  output  1  memory write strobe, registered.
REQ-012 dmem_address  output  32  word-aligned address, {addr[31:2],2'b00}.
REQ-013 dmem_wdata  output  32  lane-replicated store data.
REQ-014 dmem_mbe  output  4  byte enables.
REQ-015 dmem_rdata  input  32  read data, valid with dmem_resp.
REQ-016 dmem_resp  input  1  one-cycle completion from memory.
REQ-017 load_data  output  32  extended load result.
REQ-018 done  output  1  one-cycle completion pulse to pipeline.
REQ-019 stall  output  1  pipeline freeze request.
REQ-020 access_err  output  1  misaligned or illegal request, no access issued.

Function
REQ-021 FSM states SHALL be IDLE, ACCESS, RESP.
REQ-022 A request SHALL be req_valid & (mem_read ^ mem_write); mem_read & mem_write both 1 SHALL be illegal.
REQ-023 Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores: 000 SB, 001 SH, 010 SW; any other funct3 SHALL be illegal.
REQ-024 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0.
REQ-025 In IDLE, access_err SHALL be asserted combinationally for an illegal or misaligned request; no memory strobe and no stall SHALL result.
REQ-026 In IDLE, a legal aligned request SHALL assert stall combinationally, latch addr/funct3/store_data/direction, and move to ACCESS next edge.
REQ-027 In ACCESS, exactly one of dmem_read/dmem_write SHALL be 1; address, wdata, and mbe SHALL be held constant until dmem_resp.
REQ-028 Store mbe: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111; wdata SB {4{byte}}, SH {2{half}}, SW word.
REQ-029 Load mbe SHALL be 4'b1111.
REQ-030 stall SHALL be 1 throughout ACCESS, including the dmem_resp cycle.
REQ-031 On dmem_resp in ACCESS: strobes SHALL drop next edge, load_data SHALL be registered, and the FSM SHALL move to RESP.
REQ-032 Load extraction: byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend; LBU/LHU zero-extend; stores leave load_data unchanged.
REQ-033 In RESP: done=1 and stall=0 for exactly one cycle; req_valid SHALL be ignored; the next state SHALL be IDLE.
REQ-034 Minimum latency from request to done SHALL be 2 cycles plus memory wait; throughput SHALL be at most one access per 3 cycles.
REQ-035 dmem_resp in IDLE or RESP SHALL be ignored.
REQ-036 Inputs changing during ACCESS SHALL NOT affect the outstanding access.

Reset
REQ-037 On rst, state SHALL be IDLE and dmem_read, dmem_write, done, and stall (registered part) SHALL be 0; dmem_address, dmem_wdata, dmem_mbe, and load_data SHALL be 0.
REQ-038 rst during ACCESS SHALL abandon the access; strobes SHALL be 0 the cycle after; a later dmem_resp SHALL be ignored.

Verification
REQ-039 LW at 0x100, resp after 3 waits, rdata 0xDEADBEEF -> dmem_read 4 cycles at 0x100, then done=1 with load_data 0xDEADBEEF.
REQ-040 LB at 0x203, rdata 0x80FF7F01 -> load_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-041 SH at 0x302, store_data 0x0000ABCD -> dmem_address 0x300, mbe 4'b1100, wdata 0xABCDABCD, done after resp.
REQ-042 LW at 0x101 -> access_err=1, stall=0, no strobe; mem_read & mem_write both 1 -> access_err=1.
REQ-043 rst during ACCESS, then dmem_resp next cycle -> IDLE, no done, strobes 0.
REQ-044 Back-to-back requests with req_valid held through RESP -> exactly one access per instruction, no reissue in RESP.
